pt_fifo_flex: RTL and testbench
===============================

// Module: pt_fifo_flex
//
// PURPOSE
// - Parametrised synchronous FIFO for stream buffering between valid/ready interfaces.
// - Supports any DEPTH >= 2, including non-power-of-2 depths.
// - Optional fall-through (zero-latency bypass when empty), synchronous flush,
//   high/low watermarks, and a peak-occupancy statistic.
// - General-purpose buffer for packtype-generated stream interfaces; drop-in
//   wherever a plain FIFO with extra status and control is needed.
//
// PARAMETERS
// - DATA_T        logic [31:0]  Payload type; any packed type.
// - DEPTH         8             Storage entries; must be >= 2 (elaboration error otherwise).
// - HWM           DEPTH-1       High watermark; o_hwm asserts when level >= HWM.
// - LWM           1             Low watermark; o_lwm asserts when level <= LWM.
// - FALL_THROUGH  0             1 = write data bypasses storage to the read port when empty.
// - COUNT_W       $clog2(DEPTH+1)            localparam; level/peak width.
// - PTR_W         max(1,$clog2(DEPTH))       localparam; pointer width.
//
// PORTS
// - i_clk        in   1        Clock; all logic is rising-edge.
// - i_rst_n      in   1        Asynchronous, active-low reset.
// - i_flush      in   1        Synchronous discard of all contents.
// - i_clr_peak   in   1        Synchronous reset of o_peak to the current level.
// - i_wr_data    in   DATA_T   Push payload.
// - i_wr_valid   in   1        Push request.
// - o_wr_ready   out  1        Push accept.
// - o_rd_data    out  DATA_T   Pop payload.
// - o_rd_valid   out  1        Pop data available.
// - i_rd_ready   in   1        Pop accept.
// - o_level      out  COUNT_W  Stored entries; excludes any bypassed beat.
// - o_full       out  1        Asserted when level == DEPTH.
// - o_empty      out  1        Asserted when level == 0.
// - o_hwm        out  1        Asserted when level >= HWM.
// - o_lwm        out  1        Asserted when level <= LWM.
// - o_peak       out  COUNT_W  Maximum level since reset or i_clr_peak.
//
// BEHAVIOUR
// - Reset values:
//   - Pointers, level and o_peak are 0; storage is 0.
//   - Outputs: o_empty=1, o_lwm=1, o_full=0, o_rd_valid=0, o_wr_ready=1.
//   - o_hwm = (HWM==0).
// - Handshake:
//   - push = i_wr_valid & o_wr_ready; pop = o_rd_valid & i_rd_ready.
//   - o_wr_ready = !o_full & !i_flush.
//   - o_rd_valid must not depend on i_rd_ready.
// - Pointers:
//   - head and tail range 0..DEPTH-1 and wrap from DEPTH-1 to 0. Never index >= DEPTH.
//   - level_next = level - pop + push, computed in COUNT_W bits.
//   - A push and a pop in the same cycle leave the level unchanged.
// - FALL_THROUGH=0:
//   - o_rd_valid = !o_empty; o_rd_data = storage[tail].
//   - Data pushed at cycle N is first visible at N+1.
// - FALL_THROUGH=1:
//   - When level==0: o_rd_valid = i_wr_valid and o_rd_data = i_wr_data (combinational).
//   - If that beat is popped in the same cycle, nothing is written; level and pointers hold.
//   - If it is not popped, it is stored normally; level becomes 1.
//   - When level>0, behaviour is identical to FALL_THROUGH=0.
// - Full:
//   - No push is possible while full.
//   - A pop while full frees a slot from the next cycle; same-cycle ready does not reopen.
// - Flush:
//   - While i_flush=1: o_wr_ready=0 and o_rd_valid=0, so no push or pop occurs.
//   - Next cycle: head=tail=level=0. Storage contents are don't-care.
//   - o_peak is not cleared by flush.
// - Peak:
//   - o_peak <= max(o_peak, level_next) every cycle.
//   - i_clr_peak loads level_next; it takes priority over the max update.
// - Status outputs are derived from registered level only (glitch-free, no input paths).
// - Reset mid-operation: asynchronous return to reset values. No partial beat is held.
//
// TESTING
// - DEPTH=5, FALL_THROUGH=0: push 1..5 -> o_full=1, o_wr_ready=0.
//   - Then pop all: data out is 1..5 in order, o_empty=1, o_peak=5.
// - DEPTH=5: 12 push/pop cycles at level 2 -> pointers wrap through 4->0.
//   - Data order is preserved; level stays 2.
// - FALL_THROUGH=1, empty, i_wr_valid=1 with data 0xA5, i_rd_ready=1 -> o_rd_valid=1 same cycle.
//   - o_rd_data=0xA5; o_level stays 0.
// - Level 3, assert i_flush one cycle -> that cycle o_rd_valid=0 and o_wr_ready=0.
//   - Next cycle o_level=0, o_empty=1, o_peak=3.
// - HWM=4, LWM=1: step level 0..5..0 -> o_hwm high at levels >= 4 only; o_lwm high at levels <= 1 only.
// - Drop i_rst_n mid-stream at level 4 -> o_level=0, o_rd_valid=0, o_peak=0.
//   - All of this holds immediately, before the next clock edge.

Source files
------------

// File: rtl/pt_fifo_flex.sv
// Parametrised synchronous FIFO with optional fall-through, flush, watermarks and peak tracking.
// Handles any DEPTH >= 2, including non-power-of-2, via explicit pointer wrap.
module pt_fifo_flex #(
  parameter type         DATA_T       = logic [31:0],
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned HWM          = DEPTH - 1,
  parameter int unsigned LWM          = 1,
  parameter bit          FALL_THROUGH = 1'b0,
  localparam int unsigned COUNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W       = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_clr_peak,
  input  DATA_T              i_wr_data,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  output DATA_T              o_rd_data,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic [COUNT_W-1:0] o_level,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_hwm,
  output logic               o_lwm,
  output logic [COUNT_W-1:0] o_peak
);

  if (DEPTH < 2) begin : g_depth_chk
    $error("pt_fifo_flex: DEPTH must be >= 2");
  end

  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] FULL_LVL  = COUNT_W'(DEPTH);
  localparam bit                 HWM_RST   = (HWM == 0);

  DATA_T               mem_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [COUNT_W-1:0]  level_q, level_d;
  logic [COUNT_W-1:0]  peak_q, peak_d;
  logic                full_q, empty_q, hwm_q, lwm_q;

  logic                push_c, pop_c, bypass_c, wr_en_c, rd_en_c;
  logic                rd_valid_c;
  DATA_T               rd_data_c;

  // Read port: storage head-of-line, or the write port itself when bypassing an empty FIFO.
  always_comb begin
    rd_valid_c = !empty_q;
    rd_data_c  = mem_q[tail_q];
    if (FALL_THROUGH && empty_q) begin
      rd_valid_c = i_wr_valid;
      rd_data_c  = i_wr_data;
    end
    if (i_flush) begin
      rd_valid_c = 1'b0;
    end
  end

  assign o_wr_ready = !full_q && !i_flush;
  assign o_rd_valid = rd_valid_c;
  assign o_rd_data  = rd_data_c;

  assign push_c   = i_wr_valid && o_wr_ready;
  assign pop_c    = rd_valid_c && i_rd_ready;
  // A bypassed beat that is consumed in the same cycle never touches storage.
  assign bypass_c = FALL_THROUGH && empty_q && push_c && pop_c;
  assign wr_en_c  = push_c && !bypass_c;
  assign rd_en_c  = pop_c && !bypass_c;

  // Next-state for pointers, level and peak.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    peak_d  = peak_q;

    if (wr_en_c) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    end
    if (rd_en_c) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    end
    level_d = level_q + COUNT_W'(wr_en_c) - COUNT_W'(rd_en_c);

    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end

    if (i_clr_peak) begin
      peak_d = level_d;
    end else if (level_d > peak_q) begin
      peak_d = level_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      peak_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      hwm_q   <= HWM_RST;
      lwm_q   <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      peak_q  <= peak_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);
      hwm_q   <= (32'(level_d) >= HWM);
      lwm_q   <= (32'(level_d) <= LWM);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[head_q] <= i_wr_data;
    end
  end

  assign o_level = level_q;
  assign o_peak  = peak_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_hwm   = hwm_q;
  assign o_lwm   = lwm_q;

endmodule

// File: tb/tb_pt_fifo_flex.sv
// Scoreboarded bench for pt_fifo_flex: a registered instance (a_) and a fall-through instance (b_),
// both DEPTH=5, HWM=4, LWM=1.
module tb_pt_fifo_flex;

  typedef logic [15:0] data_t;

  logic        clk;
  logic        rst_n;

  logic        a_flush, a_clr_peak, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready;
  data_t       a_wr_data, a_rd_data;
  logic [2:0]  a_level, a_peak;
  logic        a_full, a_empty, a_hwm, a_lwm;

  logic        b_flush, b_clr_peak, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
  data_t       b_wr_data, b_rd_data;
  logic [2:0]  b_level, b_peak;
  logic        b_full, b_empty, b_hwm, b_lwm;

  int vectors;
  int miscompares;

  data_t qa[$];
  data_t qb[$];

  pt_fifo_flex #(.DATA_T(data_t), .DEPTH(5), .HWM(4), .LWM(1), .FALL_THROUGH(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush), .i_clr_peak(a_clr_peak),
    .i_wr_data(a_wr_data), .i_wr_valid(a_wr_valid), .o_wr_ready(a_wr_ready),
    .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .i_rd_ready(a_rd_ready),
    .o_level(a_level), .o_full(a_full), .o_empty(a_empty), .o_hwm(a_hwm),
    .o_lwm(a_lwm), .o_peak(a_peak)
  );

  pt_fifo_flex #(.DATA_T(data_t), .DEPTH(5), .HWM(4), .LWM(1), .FALL_THROUGH(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush), .i_clr_peak(b_clr_peak),
    .i_wr_data(b_wr_data), .i_wr_valid(b_wr_valid), .o_wr_ready(b_wr_ready),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .i_rd_ready(b_rd_ready),
    .o_level(b_level), .o_full(b_full), .o_empty(b_empty), .o_hwm(b_hwm),
    .o_lwm(b_lwm), .o_peak(b_peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Scoreboard monitors: handshakes sampled mid-cycle; pushes enqueue, pops compare against the head.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
    end else begin
      if (a_wr_valid && a_wr_ready) qa.push_back(a_wr_data);
      if (a_rd_valid && a_rd_ready) begin
        if (qa.size() == 0) chk("a_pop_unexpected", 32'(a_rd_data), 32'hDEAD);
        else chk("a_pop_data", 32'(a_rd_data), 32'(qa.pop_front()));
      end
      if (a_flush) qa.delete();
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
    end else begin
      if (b_wr_valid && b_wr_ready) qb.push_back(b_wr_data);
      if (b_rd_valid && b_rd_ready) begin
        if (qb.size() == 0) chk("b_pop_unexpected", 32'(b_rd_data), 32'hDEAD);
        else chk("b_pop_data", 32'(b_rd_data), 32'(qb.pop_front()));
      end
      if (b_flush) qb.delete();
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    {a_flush, a_clr_peak, a_wr_valid, a_rd_ready} = '0;
    {b_flush, b_clr_peak, b_wr_valid, b_rd_ready} = '0;
    a_wr_data = '0;
    b_wr_data = '0;

    #12;
    chk("rst_a_level", 32'(a_level), 0);
    chk("rst_a_empty", 32'(a_empty), 1);
    chk("rst_a_lwm", 32'(a_lwm), 1);
    chk("rst_a_full", 32'(a_full), 0);
    chk("rst_a_hwm", 32'(a_hwm), 0);
    chk("rst_a_rd_valid", 32'(a_rd_valid), 0);
    chk("rst_a_wr_ready", 32'(a_wr_ready), 1);
    chk("rst_a_peak", 32'(a_peak), 0);
    rst_n = 1'b1;
    tick();

    // Fill to full, checking watermarks on the way up.
    for (int i = 0; i < 5; i++) begin
      a_wr_valid = 1'b1;
      a_wr_data  = data_t'(i + 1);
      settle();
      chk("fill_level", 32'(a_level), 32'(i));
      chk("fill_hwm", 32'(a_hwm), (i >= 4) ? 1 : 0);
      chk("fill_lwm", 32'(a_lwm), (i <= 1) ? 1 : 0);
      chk("fill_wr_ready", 32'(a_wr_ready), 1);
      tick();
    end
    a_rd_ready = 1'b1;
    a_wr_data  = 16'h0099;
    settle();
    chk("full_level", 32'(a_level), 5);
    chk("full_flag", 32'(a_full), 1);
    chk("full_wr_ready", 32'(a_wr_ready), 0);
    chk("full_hwm", 32'(a_hwm), 1);
    chk("full_lwm", 32'(a_lwm), 0);
    chk("full_peak", 32'(a_peak), 5);
    tick();
    a_wr_valid = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      settle();
      chk("drain_level", 32'(a_level), 32'(i));
      chk("drain_hwm", 32'(a_hwm), (i >= 4) ? 1 : 0);
      chk("drain_lwm", 32'(a_lwm), (i <= 1) ? 1 : 0);
      chk("drain_wr_ready", 32'(a_wr_ready), 1);
      chk("drain_rd_valid", 32'(a_rd_valid), 1);
      tick();
    end
    a_rd_ready = 1'b0;
    settle();
    chk("drained_empty", 32'(a_empty), 1);
    chk("drained_rd_valid", 32'(a_rd_valid), 0);
    chk("drained_peak", 32'(a_peak), 5);
    tick();

    // Steady push+pop at level 2 so both pointers wrap.
    for (int i = 0; i < 2; i++) begin
      a_wr_valid = 1'b1;
      a_wr_data  = data_t'(16'h10 + i);
      tick();
    end
    a_rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_wr_data = data_t'(16'h20 + i);
      settle();
      chk("wrap_level", 32'(a_level), 2);
      tick();
    end
    a_wr_valid = 1'b0;
    tick();
    tick();
    a_rd_ready = 1'b0;
    settle();
    chk("wrap_level_end", 32'(a_level), 0);
    chk("wrap_sb_empty", 32'(qa.size()), 0);
    tick();

    // Peak clear, refill to 3, then flush.
    a_clr_peak = 1'b1;
    tick();
    a_clr_peak = 1'b0;
    settle();
    chk("clr_peak", 32'(a_peak), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      a_wr_valid = 1'b1;
      a_wr_data  = data_t'(16'h30 + i);
      tick();
    end
    a_flush    = 1'b1;
    a_rd_ready = 1'b1;
    a_wr_data  = 16'h0077;
    settle();
    chk("flush_level", 32'(a_level), 3);
    chk("flush_rd_valid", 32'(a_rd_valid), 0);
    chk("flush_wr_ready", 32'(a_wr_ready), 0);
    tick();
    {a_flush, a_wr_valid, a_rd_ready} = '0;
    settle();
    chk("post_flush_level", 32'(a_level), 0);
    chk("post_flush_empty", 32'(a_empty), 1);
    chk("post_flush_peak", 32'(a_peak), 3);
    chk("post_flush_rd_valid", 32'(a_rd_valid), 0);
    tick();

    // Fall-through instance: same-cycle bypass, stored bypass, then flush.
    b_wr_valid = 1'b1;
    b_wr_data  = 16'h00A5;
    b_rd_ready = 1'b1;
    settle();
    chk("ft_rd_valid", 32'(b_rd_valid), 1);
    chk("ft_rd_data", 32'(b_rd_data), 32'h00A5);
    chk("ft_level", 32'(b_level), 0);
    tick();
    b_wr_data  = 16'h005A;
    b_rd_ready = 1'b0;
    settle();
    chk("ft_after_bypass_level", 32'(b_level), 0);
    chk("ft_after_bypass_empty", 32'(b_empty), 1);
    chk("ft_hold_rd_data", 32'(b_rd_data), 32'h005A);
    tick();
    b_wr_data  = 16'h005B;
    b_rd_ready = 1'b1;
    settle();
    chk("ft_stored_level", 32'(b_level), 1);
    chk("ft_stored_rd_data", 32'(b_rd_data), 32'h005A);
    tick();
    b_wr_valid = 1'b0;
    settle();
    chk("ft_pp_level", 32'(b_level), 1);
    chk("ft_pp_rd_data", 32'(b_rd_data), 32'h005B);
    tick();
    b_rd_ready = 1'b0;
    settle();
    chk("ft_idle_level", 32'(b_level), 0);
    chk("ft_idle_rd_valid", 32'(b_rd_valid), 0);
    tick();
    b_flush    = 1'b1;
    b_wr_valid = 1'b1;
    b_wr_data  = 16'h00C3;
    b_rd_ready = 1'b1;
    settle();
    chk("ft_flush_rd_valid", 32'(b_rd_valid), 0);
    chk("ft_flush_wr_ready", 32'(b_wr_ready), 0);
    tick();
    {b_flush, b_wr_valid, b_rd_ready} = '0;
    settle();
    chk("ft_post_flush_level", 32'(b_level), 0);
    chk("ft_peak", 32'(b_peak), 1);
    chk("ft_sb_empty", 32'(qb.size()), 0);
    tick();

    // Asynchronous reset mid-stream at level 4.
    for (int i = 0; i < 4; i++) begin
      a_wr_valid = 1'b1;
      a_wr_data  = data_t'(16'h40 + i);
      tick();
    end
    a_wr_valid = 1'b0;
    settle();
    chk("prerst_level", 32'(a_level), 4);
    chk("prerst_peak", 32'(a_peak), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(a_level), 0);
    chk("arst_rd_valid", 32'(a_rd_valid), 0);
    chk("arst_peak", 32'(a_peak), 0);
    chk("arst_empty", 32'(a_empty), 1);
    chk("arst_hwm", 32'(a_hwm), 0);
    chk("arst_lwm", 32'(a_lwm), 1);
    settle();
    #2;
    rst_n = 1'b1;
    tick();
    settle();
    chk("post_rst_level", 32'(a_level), 0);
    chk("post_rst_rd_valid", 32'(a_rd_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
